// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the program counter, issues one instruction
// memory request at a time, and hands each fetched word (with its PC and
// PC+4) to decode over a valid/ready handshake. Redirects replace the PC and
// may leave one stale memory response to be squashed. Fetch stops for good
// once the halt instruction is accepted downstream.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INST = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_reqAddr;
    logic        r_squash;
    logic        r_inReset;
    logic [31:0] r_inst;
    logic [31:0] r_instPc;
    logic [31:0] r_instPcPlus4;
    logic [31:0] r_fetchCount;

    state_t      w_stateNext;
    logic [31:0] w_pcNext;
    logic        w_squashNext;
    logic        w_capture;
    logic        w_accept;
    logic [31:0] w_redirectAligned;
    logic        w_holdAddr;

    assign w_redirectAligned = redirect_pc & PC_MASK;

    // While a request is outstanding its address must stay put, even if the
    // PC has already been redirected underneath it.
    assign w_holdAddr = (r_state == FETCH) && !imem_rvalid;

    // Next-state, next-PC and squash decisions for the fetch handshake.
    always_comb begin
        w_stateNext  = r_state;
        w_pcNext     = r_pc;
        w_squashNext = r_squash;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            FETCH: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        w_pcNext     = w_redirectAligned;
                        w_squashNext = 1'b0;
                    end else if (r_squash) begin
                        w_squashNext = 1'b0;
                    end else begin
                        w_capture   = 1'b1;
                        w_stateNext = HOLD;
                    end
                end else if (redirect) begin
                    w_pcNext     = w_redirectAligned;
                    w_squashNext = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_pcNext    = w_redirectAligned;
                    w_stateNext = FETCH;
                end else if (inst_ready) begin
                    w_accept = 1'b1;
                    if (r_inst == HALT_INST) begin
                        w_stateNext = HALTED;
                    end else begin
                        w_pcNext    = r_pc + 32'd4;
                        w_stateNext = FETCH;
                    end
                end
            end
            HALTED: begin
                w_stateNext = HALTED;
            end
            default: begin
                w_stateNext = FETCH;
            end
        endcase
    end

    // State, PC, request address and presented-instruction registers.
    // A reset that lands while a request is in flight (and not in a run of
    // back-to-back reset cycles) marks the late response as stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC & PC_MASK;
            r_reqAddr     <= RESET_PC & PC_MASK;
            r_squash      <= !r_inReset && (r_state == FETCH) && !imem_rvalid;
            r_inReset     <= 1'b1;
            r_inst        <= 32'd0;
            r_instPc      <= 32'd0;
            r_instPcPlus4 <= 32'd0;
            r_fetchCount  <= 32'd0;
        end else begin
            r_state   <= w_stateNext;
            r_pc      <= w_pcNext;
            r_squash  <= w_squashNext;
            r_inReset <= 1'b0;
            if (!w_holdAddr) begin
                r_reqAddr <= w_pcNext;
            end
            if (w_capture) begin
                r_inst        <= imem_rdata;
                r_instPc      <= r_pc;
                r_instPcPlus4 <= r_pc + 32'd4;
            end
            if (w_accept) begin
                r_fetchCount <= r_fetchCount + 32'd1;
            end
        end
    end

    assign imem_req      = (r_state == FETCH) && !rst;
    assign imem_addr     = r_reqAddr;
    assign inst          = r_inst;
    assign inst_pc       = r_instPc;
    assign inst_pc_plus4 = r_instPcPlus4;
    assign inst_valid    = (r_state == HOLD);
    assign halted        = (r_state == HALTED);
    assign fetch_count   = r_fetchCount;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a memory model serves requests
// with programmable latency, expected request addresses and accepted
// instructions are queued by the stimulus and compared by monitors.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = 32'd0;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic [31:0] instPcPlus4;
    logic        instValid;
    logic        instReady = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = 32'd0;
    logic        halted;
    logic [31:0] fetchCount;

    logic        imemReq1;
    logic [31:0] imemAddr1;
    logic        rvalid1 = 1'b0;
    logic [31:0] rdata1 = 32'd0;
    logic [31:0] inst1;
    logic [31:0] instPc1;
    logic [31:0] instPcPlus41;
    logic        instValid1;
    logic        ready1 = 1'b0;
    logic        halted1;
    logic [31:0] fetchCount1;

    int checkCount = 0;
    int failCount  = 0;
    int memLat     = 1;

    logic [31:0] addrQ [$];
    logic [95:0] instQ [$];

    inst_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imemReq), .imem_addr(imemAddr),
        .imem_rvalid(imemRvalid), .imem_rdata(imemRdata),
        .inst(inst), .inst_pc(instPc), .inst_pc_plus4(instPcPlus4),
        .inst_valid(instValid), .inst_ready(instReady),
        .redirect(redirect), .redirect_pc(redirectPc),
        .halted(halted), .fetch_count(fetchCount)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .rst(rst),
        .imem_req(imemReq1), .imem_addr(imemAddr1),
        .imem_rvalid(rvalid1), .imem_rdata(rdata1),
        .inst(inst1), .inst_pc(instPc1), .inst_pc_plus4(instPcPlus41),
        .inst_valid(instValid1), .inst_ready(ready1),
        .redirect(1'b0), .redirect_pc(32'd0),
        .halted(halted1), .fetch_count(fetchCount1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0000: memWord = 32'h2008_0005;
            32'h0000_0004: memWord = 32'h2009_0003;
            32'h0000_0008: memWord = 32'hDEAD_BEEF;
            32'h0000_0040: memWord = 32'h2222_2222;
            32'h0000_0100: memWord = 32'h0000_000C;
            default:       memWord = 32'h0000_0013;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] redirPc,
                                 input logic ready);
        redirect   = redir;
        redirectPc = redirPc;
        instReady  = ready;
    endtask

    // kind 0: inst_valid, 1: fetch_count==value, 2: halted
    task automatic waitUntil(input int kind, input logic [31:0] value, input int budget);
        bit hit = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((kind == 0 && instValid) || (kind == 1 && fetchCount == value) ||
                (kind == 2 && halted)) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL wait_kind%0d: condition not reached within %0d cycles", kind, budget);
        end
    endtask

    // Instruction memory model: one outstanding request, fixed latency.
    initial begin
        logic [31:0] a;
        forever begin
            @(posedge clk);
            #2;
            imemRvalid = 1'b0;
            if (imemReq) begin
                a = imemAddr;
                if (addrQ.size() == 0) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL req_unexpected: got addr 0x%08h expected no request", a);
                end else begin
                    checkOutput("imem_addr", a, addrQ.pop_front());
                end
                repeat (memLat) @(posedge clk);
                #2;
                imemRvalid = 1'b1;
                imemRdata  = memWord(a);
            end
        end
    end

    // Scoreboard monitor: every accepted instruction is compared to the queue.
    always @(negedge clk) begin
        logic [95:0] e;
        if (!rst && instValid && instReady && !redirect) begin
            if (instQ.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL inst_unexpected: got pc 0x%08h expected no accept", instPc);
            end else begin
                e = instQ.pop_front();
                checkOutput("acc_inst", inst, e[95:64]);
                checkOutput("acc_pc", instPc, e[63:32]);
                checkOutput("acc_pc4", instPcPlus4, e[31:0]);
            end
        end
    end

    // Wrap-around PC instance driven by hand.
    initial begin
        wait (rst == 1'b0);
        #1;
        checkOutput("wrap_addr0", imemAddr1, 32'hFFFF_FFFC);
        checkOutput("wrap_req0", {31'd0, imemReq1}, 32'd1);
        step();
        rvalid1 = 1'b1;
        rdata1  = 32'h0000_0013;
        step();
        rvalid1 = 1'b0;
        checkOutput("wrap_valid", {31'd0, instValid1}, 32'd1);
        checkOutput("wrap_pc", instPc1, 32'hFFFF_FFFC);
        checkOutput("wrap_pc4", instPcPlus41, 32'h0000_0000);
        ready1 = 1'b1;
        step();
        ready1 = 1'b0;
        checkOutput("wrap_addr1", imemAddr1, 32'h0000_0000);
        checkOutput("wrap_count", fetchCount1, 32'd1);
    end

    initial begin
        applyStimulus(1'b0, 32'd0, 1'b0);
        repeat (3) step();
        checkOutput("rst_req", {31'd0, imemReq}, 32'd0);
        checkOutput("rst_valid", {31'd0, instValid}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_count", fetchCount, 32'd0);
        checkOutput("rst_inst", inst, 32'd0);
        checkOutput("rst_pc", instPc, 32'd0);

        addrQ.push_back(32'h0);
        addrQ.push_back(32'h4);
        addrQ.push_back(32'h8);
        addrQ.push_back(32'h40);
        instQ.push_back({32'h2008_0005, 32'h0, 32'h4});
        instQ.push_back({32'h2009_0003, 32'h4, 32'h8});
        rst = 1'b0;

        waitUntil(0, 32'd0, 20);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_inst", inst, 32'h2008_0005);
            checkOutput("hold_pc", instPc, 32'h0);
            checkOutput("hold_valid", {31'd0, instValid}, 32'd1);
            checkOutput("hold_req", {31'd0, imemReq}, 32'd0);
            checkOutput("hold_count", fetchCount, 32'd0);
            step();
        end

        memLat = 3;
        applyStimulus(1'b0, 32'd0, 1'b1);
        waitUntil(1, 32'd2, 40);
        applyStimulus(1'b1, 32'h0000_0040, 1'b0);
        step();
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("stale_addr_a", imemAddr, 32'h8);
        checkOutput("stale_req_a", {31'd0, imemReq}, 32'd1);
        step();
        checkOutput("stale_addr_b", imemAddr, 32'h8);

        waitUntil(0, 32'd0, 30);
        checkOutput("redir_pc", instPc, 32'h40);
        checkOutput("redir_inst", inst, 32'h2222_2222);
        checkOutput("redir_pc4", instPcPlus4, 32'h44);

        memLat = 1;
        addrQ.push_back(32'h100);
        instQ.push_back({32'h0000_000C, 32'h100, 32'h104});
        applyStimulus(1'b1, 32'h0000_0103, 1'b1);
        step();
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("drop_count", fetchCount, 32'd2);
        checkOutput("drop_addr", imemAddr, 32'h100);
        checkOutput("drop_req", {31'd0, imemReq}, 32'd1);

        waitUntil(2, 32'd0, 20);
        checkOutput("halt_count", fetchCount, 32'd3);
        checkOutput("halt_req", {31'd0, imemReq}, 32'd0);
        checkOutput("halt_valid", {31'd0, instValid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0000_0200, 1'b1);
            step();
            checkOutput("halt_stay", {31'd0, halted}, 32'd1);
            checkOutput("halt_req_stay", {31'd0, imemReq}, 32'd0);
        end
        applyStimulus(1'b0, 32'd0, 1'b0);

        addrQ.push_back(32'h0);
        rst = 1'b1;
        step();
        step();
        checkOutput("rerst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rerst_count", fetchCount, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rerst_addr", imemAddr, 32'h0);
        checkOutput("rerst_req", {31'd0, imemReq}, 32'd1);
        waitUntil(0, 32'd0, 20);
        checkOutput("rerst_pc", instPc, 32'h0);
        checkOutput("rerst_inst", inst, 32'h2008_0005);

        step();
        checkOutput("instQ_left", instQ.size(), 32'd0);
        checkOutput("addrQ_left", addrQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
